// File: rtl/masked_arith_accumulator.sv
// Share-wise accumulator for arithmetic-masked samples: sums N_ACC samples (or a flushed partial
// frame) mod 2^K_WIDTH and emits one frame. Define MASKED_ACC_REFRESH_EN to re-randomise shares on emit.
module masked_arith_accumulator #(
  parameter int K_WIDTH  = 16,
  parameter int N_SHARES = 3,
  parameter int N_ACC    = 4,
  localparam int CW      = $clog2(N_ACC + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ena,
  input  logic                            dvld,
  input  logic [K_WIDTH*N_SHARES-1:0]     i_a,
  input  logic                            flush,
  input  logic [K_WIDTH*(N_SHARES-1)-1:0] rnd,
  output logic [K_WIDTH*N_SHARES-1:0]     o_a,
  output logic [CW-1:0]                   o_cnt,
  output logic                            ovld
);

  typedef logic [N_SHARES-1:0][K_WIDTH-1:0] shares_t;

  shares_t       r_acc;
  shares_t       r_oa;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_ocnt;
  logic          r_ovld;

  shares_t       w_acc_n;
  shares_t       w_out;
  logic [CW-1:0] w_cnt_n;
  logic          w_acc;
  logic          w_emit;

  always_comb begin
    w_acc = ena & dvld;
    for (int i = 0; i < N_SHARES; i++) begin
      w_acc_n[i] = r_acc[i] + (w_acc ? i_a[i*K_WIDTH +: K_WIDTH] : '0);
    end
    w_cnt_n = r_cnt + CW'(w_acc);
    w_emit  = ena & ((w_acc & (r_cnt == CW'(N_ACC - 1))) | (flush & (w_cnt_n != '0)));
  end

`ifdef MASKED_ACC_REFRESH_EN
  // Add a fresh mask to every share but the last, which absorbs their sum so the total is unchanged.
  function automatic shares_t refresh(input shares_t s, input logic [K_WIDTH*(N_SHARES-1)-1:0] r);
    logic [K_WIDTH-1:0] rsum;
    rsum = '0;
    for (int i = 0; i < N_SHARES - 1; i++) begin
      refresh[i] = s[i] + r[i*K_WIDTH +: K_WIDTH];
      rsum       = rsum + r[i*K_WIDTH +: K_WIDTH];
    end
    refresh[N_SHARES-1] = s[N_SHARES-1] - rsum;
  endfunction

  assign w_out = refresh(w_acc_n, rnd);
`else
  logic w_unused_rnd;
  assign w_unused_rnd = ^rnd;
  assign w_out        = w_acc_n;
`endif

  // Output register stage: the emit cycle closes the frame and clears the accumulator in one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_oa   <= '0;
      r_ocnt <= '0;
      r_ovld <= 1'b0;
    end else begin
      r_ovld <= w_emit;
      if (w_emit) begin
        r_oa   <= w_out;
        r_ocnt <= w_cnt_n;
        r_acc  <= '0;
        r_cnt  <= '0;
      end else if (ena) begin
        r_acc  <= w_acc_n;
        r_cnt  <= w_cnt_n;
      end
    end
  end

  assign o_a   = r_oa;
  assign o_cnt = r_ocnt;
  assign ovld  = r_ovld;

endmodule

// File: tb/tb_masked_arith_accumulator.sv
// Scoreboard bench for masked_arith_accumulator: a reference model queues expected frames as
// stimulus is driven; a negedge monitor checks ovld every cycle and pops/compares each frame.
module tb_masked_arith_accumulator;
  localparam int K  = 16;
  localparam int N  = 3;
  localparam int NA = 4;
  localparam int CW = $clog2(NA + 1);

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             ena   = 1'b0;
  logic             dvld  = 1'b0;
  logic             flush = 1'b0;
  logic [N*K-1:0]   i_a   = '0;
  logic [(N-1)*K-1:0] rnd = '0;
  logic [N*K-1:0]   o_a;
  logic [CW-1:0]    o_cnt;
  logic             ovld;

  masked_arith_accumulator #(.K_WIDTH(K), .N_SHARES(N), .N_ACC(NA)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .dvld(dvld), .i_a(i_a), .flush(flush),
    .rnd(rnd), .o_a(o_a), .o_cnt(o_cnt), .ovld(ovld)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N*K-1:0] oa;
    logic [CW-1:0]  cnt;
    logic [K-1:0]   usum;
  } frame_t;

  frame_t       sb[$];
  logic [K-1:0] m_acc[N];
  int           m_cnt;
  logic [K-1:0] m_usum;
  logic         exp_ovld = 1'b0;
  int           n_tests  = 0;
  int           n_fail   = 0;
  frame_t       mon_fr;
  logic [K-1:0] mon_sum;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N*K-1:0] pack3(input logic [K-1:0] s0, s1, s2);
    return {s2, s1, s0};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) m_acc[i] = '0;
    m_cnt  = 0;
    m_usum = '0;
  endtask

  // Drive one cycle of stimulus; the model predicts whether the next edge emits and with what.
  task automatic step(input bit e, input bit v, input logic [N*K-1:0] a, input bit f,
                      input logic [(N-1)*K-1:0] r);
    frame_t       fr;
    bit           acc, emit;
    int           cn;
    logic [K-1:0] an[N];
    logic [K-1:0] rs, usum_n;
    ena = e; dvld = v; i_a = a; flush = f; rnd = r;
    acc    = e && v;
    usum_n = m_usum;
    for (int i = 0; i < N; i++) begin
      an[i] = m_acc[i] + (acc ? a[i*K +: K] : K'(0));
      if (acc) usum_n = usum_n + a[i*K +: K];
    end
    cn   = m_cnt + (acc ? 1 : 0);
    emit = e && ((acc && m_cnt == NA - 1) || (f && cn != 0));
    if (emit) begin
      rs = '0;
      for (int i = 0; i < N - 1; i++) begin
`ifdef MASKED_ACC_REFRESH_EN
        fr.oa[i*K +: K] = an[i] + r[i*K +: K];
        rs = rs + r[i*K +: K];
`else
        fr.oa[i*K +: K] = an[i];
`endif
      end
      fr.oa[(N-1)*K +: K] = an[N-1] - rs;
      fr.cnt  = CW'(cn);
      fr.usum = usum_n;
      model_clear();
    end else if (e) begin
      for (int i = 0; i < N; i++) m_acc[i] = an[i];
      m_cnt  = cn;
      m_usum = usum_n;
    end
    @(posedge clk);
    #1;
    exp_ovld = emit;
    if (emit) sb.push_back(fr);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, '0, 1'b0, '0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("ovld", {63'd0, ovld}, {63'd0, exp_ovld});
      if (exp_ovld) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          mon_fr  = sb.pop_front();
          mon_sum = '0;
          for (int i = 0; i < N; i++) begin
            check($sformatf("o_a[%0d]", i), 64'(o_a[i*K +: K]), 64'(mon_fr.oa[i*K +: K]));
            mon_sum = mon_sum + o_a[i*K +: K];
          end
          check("o_cnt", 64'(o_cnt), 64'(mon_fr.cnt));
          check("share_sum", 64'(mon_sum), 64'(mon_fr.usum));
        end
      end
    end
  end

  initial begin
    logic [(N-1)*K-1:0] rw;
    logic [K-1:0]       x, s0, s1;
    model_clear();

    // Power-on reset
    #2;
    check("rst_o_a", 64'(o_a), 64'd0);
    check("rst_o_cnt", 64'(o_cnt), 64'd0);
    check("rst_ovld", {63'd0, ovld}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Two samples, then asynchronous reset mid-frame discards them
    step(1, 1, pack3(16'd7, 16'd8, 16'd9), 0, '0);
    step(1, 1, pack3(16'd7, 16'd8, 16'd9), 0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_o_a", 64'(o_a), 64'd0);
    check("arst_o_cnt", 64'(o_cnt), 64'd0);
    check("arst_ovld", {63'd0, ovld}, 64'd0);
    model_clear();
    exp_ovld = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Clean full frame with zero randomness: (4,8,12), cnt 4
    for (int k = 0; k < NA; k++) step(1, 1, pack3(16'd1, 16'd2, 16'd3), 0, '0);
    idle(2);

    // Refresh with wrap-around: unmasked sum is zero
    rw = {16'h0F0F, 16'h1234};
    for (int k = 0; k < NA; k++) step(1, 1, pack3(16'hFFFF, 16'd1, 16'd0), 0, rw);
    idle(2);

    // Partial frame by flush, then empty flush is ignored
    step(1, 1, pack3(16'd5, 16'd0, 16'd0), 0, '0);
    step(1, 1, pack3(16'd5, 16'd0, 16'd0), 0, '0);
    step(1, 0, '0, 1, 32'hA5A5_5A5A);
    step(1, 0, '0, 1, '0);
    idle(1);

    // Flush coinciding with the 4th sample gives a single full frame
    for (int k = 0; k < NA - 1; k++) step(1, 1, pack3(16'd3, 16'd4, 16'd5), 0, '0);
    step(1, 1, pack3(16'd3, 16'd4, 16'd5), 1, 32'h1111_2222);
    step(1, 0, '0, 1, '0);
    idle(1);

    // Flush and sample while disabled are ignored, not queued
    step(1, 1, pack3(16'd9, 16'd0, 16'd1), 0, '0);
    step(0, 1, pack3(16'd9, 16'd0, 16'd1), 1, '0);
    step(0, 0, '0, 1, '0);
    step(1, 0, '0, 1, 32'h0000_0001);
    idle(1);

    // Streaming with random shares; ena drops for 3 cycles mid-run
    for (int k = 0; k < 40; k++) begin
      step((k >= 13 && k < 16) ? 1'b0 : 1'b1, 1'b1,
           pack3(K'($urandom), K'($urandom), K'($urandom)), 1'b0, {K'($urandom), K'($urandom)});
    end
    step(1, 0, '0, 1, {K'($urandom), K'($urandom)});
    idle(1);

    // SecB2A-style chain: Boolean value re-expressed as three arithmetic shares
    for (int k = 0; k < 24; k++) begin
      x  = K'($urandom);
      s0 = K'($urandom);
      s1 = K'($urandom);
      step(1, ($urandom_range(0, 3) != 0), pack3(s0, s1, x - s0 - s1),
           (k == 23), {K'($urandom), K'($urandom)});
    end
    idle(3);

    check("sb_drain", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
